// File: rtl/mem_ctrl_if.sv
// Pipeline-side request/response signals and RAM pins shared by mem_ctrl.
// slave = controller view, master = pipeline stages plus RAM environment.
interface mem_ctrl_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  ram_din_i;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic        io_buffer_full_i;
    logic        busy_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i, io_buffer_full_i,
        output if_done_o, if_data_o, mem_done_o, mem_rdata_o,
        output ram_dout_o, ram_a_o, ram_wr_o, busy_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output ram_din_i, io_buffer_full_i,
        input  if_done_o, if_data_o, mem_done_o, mem_rdata_o,
        input  ram_dout_o, ram_a_o, ram_wr_o, busy_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating the 8-bit RAM port between IF and MEM.
// Optional MEMCTRL_IO_FULL_WAIT_EN: stall writes to the UART window while its buffer is full.
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic        owner_q, owner_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic        ram_wr_q, ram_wr_d;
    logic        busy_q, busy_d;

    logic [31:0] byte_addr;
    logic [1:0]  cap_idx;
    logic        io_full;

`ifdef MEMCTRL_IO_FULL_WAIT_EN
    assign io_full = bus.io_buffer_full_i;
`else
    logic unused_io_full;
    assign unused_io_full = bus.io_buffer_full_i;
    assign io_full        = 1'b0;
`endif

    function automatic logic [2:0] len_bytes(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Writes into the UART window (addr[17:16] == 2'b11) wait while its buffer is full.
    function automatic logic io_stall(input logic [31:0] a, input logic full);
        return (a[17:16] == 2'b11) && full;
    endfunction

    assign byte_addr = base_q + {29'd0, cnt_q};
    // Byte k is captured two edges after its address, i.e. when cnt == k + 2.
    assign cap_idx   = cnt_q[1:0] - 2'd2;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        owner_d     = owner_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        ram_dout_d  = ram_dout_q;
        ram_a_d     = ram_a_q;
        ram_wr_d    = ram_wr_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_req_i && !mem_done_q) begin
                    owner_d = OWN_MEM;
                    base_d  = bus.mem_addr_i;
                    len_d   = len_bytes(bus.mem_len_i);
                    wdata_d = bus.mem_wdata_i;
                    acc_d   = '0;
                    ram_a_d = bus.mem_addr_i;
                    busy_d  = 1'b1;
                    if (bus.mem_we_i) begin
                        state_d = S_WRITE;
                        if (io_stall(bus.mem_addr_i, io_full)) begin
                            ram_wr_d = 1'b0;
                            cnt_d    = 3'd0;
                        end else begin
                            ram_wr_d   = 1'b1;
                            ram_dout_d = bus.mem_wdata_i[7:0];
                            cnt_d      = 3'd1;
                        end
                    end else begin
                        state_d  = S_READ;
                        ram_wr_d = 1'b0;
                        cnt_d    = 3'd1;
                    end
                end else if (bus.if_req_i && !if_done_q && !bus.if_flush_i) begin
                    owner_d  = OWN_IF;
                    base_d   = bus.if_addr_i;
                    len_d    = 3'd4;
                    acc_d    = '0;
                    ram_a_d  = bus.if_addr_i;
                    ram_wr_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_READ;
                    cnt_d    = 3'd1;
                end
            end

            S_READ: begin
                if (owner_q == OWN_IF && bus.if_flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b0;
                end else begin
                    if (cnt_q < len_q)
                        ram_a_d = byte_addr;
                    if (cnt_q >= 3'd2)
                        acc_d[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        busy_d  = 1'b0;
                        if (owner_q == OWN_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = acc_d;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = acc_d;
                        end
                    end
                end
            end

            S_WRITE: begin
                if (cnt_q == len_q) begin
                    state_d    = S_IDLE;
                    cnt_d      = 3'd0;
                    ram_wr_d   = 1'b0;
                    busy_d     = 1'b0;
                    mem_done_d = 1'b1;
                end else begin
                    ram_a_d = byte_addr;
                    if (io_stall(byte_addr, io_full)) begin
                        ram_wr_d = 1'b0;
                    end else begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            owner_q     <= OWN_IF;
            base_q      <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
            ram_dout_q  <= '0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
            ram_dout_q  <= ram_dout_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_done_o   = if_done_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.mem_done_o  = mem_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.ram_dout_o  = ram_dout_q;
    assign bus.ram_a_o     = ram_a_q;
    assign bus.ram_wr_o    = ram_wr_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single transactions plus hand-written
// sequences for arbitration, flush, reset mid-store and the UART-full stall.
module tb_mem_ctrl;

    logic clk;
    logic rst;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide synchronous RAM: data for the address seen at one edge appears after the next.
    logic [7:0]  ram [0:65535];
    logic        tb_we;
    logic [15:0] tb_wa;
    logic [7:0]  tb_wd;

    always @(posedge clk) begin
        bus.ram_din_i <= ram[bus.ram_a_o[15:0]];
        if (tb_we)
            ram[tb_wa] <= tb_wd;
        else if (bus.ram_wr_o)
            ram[bus.ram_a_o[15:0]] <= bus.ram_dout_o;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_if;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Waits for the chosen done pulse; edges counts negedges after the grant edge.
    task automatic wait_done(input logic want_if, input int max_edges, input int first,
                             output int edges, output logic [31:0] data, output logic busy_at);
        logic seen;
        seen    = 1'b0;
        edges   = -1;
        data    = '0;
        busy_at = 1'b1;
        for (int i = first; i <= max_edges && !seen; i++) begin
            @(negedge clk);
            if (want_if ? bus.if_done_o : bus.mem_done_o) begin
                seen    = 1'b1;
                edges   = i;
                data    = want_if ? bus.if_data_o : bus.mem_rdata_o;
                busy_at = bus.busy_o;
            end
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int          edges;
        logic [31:0] data;
        logic        busy_at;
        @(negedge clk);
        if (v.is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = v.addr;
        end else begin
            bus.mem_req_i   = 1'b1;
            bus.mem_we_i    = v.we;
            bus.mem_len_i   = v.len;
            bus.mem_addr_i  = v.addr;
            bus.mem_wdata_i = v.wdata;
        end
        wait_done(v.is_if, 20, 1, edges, data, busy_at);
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
        bus.mem_we_i  = 1'b0;
        check({tag, "_latency"}, edges, v.exp_lat);
        if (v.chk)
            check({tag, "_data"}, data, v.exp_data);
        check({tag, "_busy_in_done"}, 32'(busy_at), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(v.is_if ? bus.if_done_o : bus.mem_done_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        logic [15:0] pa [18];
        logic [7:0]  pd [18];
        int          edges;
        logic [31:0] data;
        logic        busy_at;
        logic        early;

        bus.if_req_i         = 1'b0;
        bus.if_addr_i        = '0;
        bus.if_flush_i       = 1'b0;
        bus.mem_req_i        = 1'b0;
        bus.mem_we_i         = 1'b0;
        bus.mem_len_i        = '0;
        bus.mem_addr_i       = '0;
        bus.mem_wdata_i      = '0;
        bus.io_buffer_full_i = 1'b0;
        tb_we = 1'b0;
        tb_wa = '0;
        tb_wd = '0;
        rst   = 1'b1;
        #1 rst = 1'b0;

        #10;
        check("reset_busy",      32'(bus.busy_o),     32'd0);
        check("reset_ram_wr",    32'(bus.ram_wr_o),   32'd0);
        check("reset_ram_a",     bus.ram_a_o,         32'd0);
        check("reset_ram_dout",  32'(bus.ram_dout_o), 32'd0);
        check("reset_if_done",   32'(bus.if_done_o),  32'd0);
        check("reset_mem_done",  32'(bus.mem_done_o), 32'd0);
        check("reset_if_data",   bus.if_data_o,       32'd0);
        check("reset_mem_rdata", bus.mem_rdata_o,     32'd0);

        pa = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h1004, 16'h0200,
               16'h0201, 16'h0202, 16'h0203, 16'h0300, 16'h0301, 16'hFFFE,
               16'hFFFF, 16'h0000, 16'h0001, 16'h0501, 16'h0502, 16'h0503};
        pd = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h78,
               8'h56, 8'h34, 8'h12, 8'hAA, 8'hBB, 8'h11,
               8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
        @(negedge clk);
        for (int i = 0; i < 18; i++) poke(pa[i], pd[i]);
        rst = 1'b1;

        // {is_if, we, len, addr, wdata, chk, exp_data, exp_lat}
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,          1'b1, 32'h0000_0513, 6};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'h0,          1'b1, 32'h1234_5678, 6};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0300, 32'h0,          1'b1, 32'h0000_BBAA, 4};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0301, 32'h0,          1'b1, 32'h0000_00BB, 3};
        vecs[4]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0200, 32'h0,          1'b1, 32'h1234_5678, 6};
        vecs[5]  = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,          1'b1, 32'h4433_2211, 6};
        vecs[6]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0400, 32'hCAFE_F00D,  1'b0, 32'h0,         5};
        vecs[7]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0,          1'b1, 32'hCAFE_F00D, 6};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0401, 32'h1234_565A,  1'b0, 32'h0,         2};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0,          1'b1, 32'hCAFE_5A0D, 6};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 32'h0000_0402, 32'h9999_BEEF,  1'b0, 32'h0,         3};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0,          1'b1, 32'hBEEF_5A0D, 6};

        for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: MEM first, IF granted on the edge ending mem_done.
        @(negedge clk);
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0000_0100;
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_len_i  = 2'b00;
        bus.mem_addr_i = 32'h0000_1004;
        @(negedge clk);
        check("arb_mem_first_addr", bus.ram_a_o, 32'h0000_1004);
        wait_done(1'b0, 10, 2, edges, data, busy_at);
        check("arb_mem_latency", edges, 32'd3);
        check("arb_mem_rdata", data, 32'h0000_00FF);
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        check("arb_if_grant_addr", bus.ram_a_o, 32'h0000_0100);
        check("arb_if_grant_busy", 32'(bus.busy_o), 32'd1);
        wait_done(1'b1, 10, 2, edges, data, busy_at);
        bus.if_req_i = 1'b0;
        check("arb_if_latency", edges, 32'd6);
        check("arb_if_data", data, 32'h0000_0513);

        // Store half 0xBEEF to 0x2002, watching the RAM pins cycle by cycle.
        @(negedge clk);
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_len_i   = 2'b01;
        bus.mem_addr_i  = 32'h0000_2002;
        bus.mem_wdata_i = 32'h1234_BEEF;
        @(negedge clk);
        check("sth_b0_wr",   32'(bus.ram_wr_o),   32'd1);
        check("sth_b0_addr", bus.ram_a_o,         32'h0000_2002);
        check("sth_b0_dout", 32'(bus.ram_dout_o), 32'h0000_00EF);
        @(negedge clk);
        check("sth_b1_wr",   32'(bus.ram_wr_o),   32'd1);
        check("sth_b1_addr", bus.ram_a_o,         32'h0000_2003);
        check("sth_b1_dout", 32'(bus.ram_dout_o), 32'h0000_00BE);
        check("sth_b1_done", 32'(bus.mem_done_o), 32'd0);
        @(negedge clk);
        check("sth_end_wr",   32'(bus.ram_wr_o),   32'd0);
        check("sth_end_done", 32'(bus.mem_done_o), 32'd1);
        check("sth_end_busy", 32'(bus.busy_o),     32'd0);
        bus.mem_req_i = 1'b0;
        bus.mem_we_i  = 1'b0;

        // Flush after the second fetch address, then restart at the branch target.
        @(negedge clk);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0200;
        @(negedge clk);
        check("flush_a0", bus.ram_a_o, 32'h0000_0200);
        @(negedge clk);
        check("flush_a1", bus.ram_a_o, 32'h0000_0201);
        bus.if_flush_i = 1'b1;
        @(negedge clk);
        early = bus.if_done_o;
        check("flush_busy_low", 32'(bus.busy_o), 32'd0);
        bus.if_addr_i = 32'h0000_0100;
        @(negedge clk);
        early = early | bus.if_done_o;
        check("flush_blocks_grant", 32'(bus.busy_o), 32'd0);
        check("flush_no_if_done", 32'(early), 32'd0);
        bus.if_flush_i = 1'b0;
        wait_done(1'b1, 10, 1, edges, data, busy_at);
        bus.if_req_i = 1'b0;
        check("flush_target_latency", edges, 32'd6);
        check("flush_target_data", data, 32'h0000_0513);

        // Flush must not disturb a MEM load.
        @(negedge clk);
        bus.if_flush_i = 1'b1;
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_len_i  = 2'b10;
        bus.mem_addr_i = 32'h0000_0200;
        wait_done(1'b0, 10, 1, edges, data, busy_at);
        bus.mem_req_i  = 1'b0;
        bus.if_flush_i = 1'b0;
        check("flush_mem_latency", edges, 32'd6);
        check("flush_mem_data", data, 32'h1234_5678);

        // Asynchronous reset in the middle of a word store.
        @(negedge clk);
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_len_i   = 2'b10;
        bus.mem_addr_i  = 32'h0000_0500;
        bus.mem_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_addr", bus.ram_a_o, 32'h0000_0501);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ram_wr",    32'(bus.ram_wr_o),   32'd0);
        check("rst_mid_ram_a",     bus.ram_a_o,         32'd0);
        check("rst_mid_ram_dout",  32'(bus.ram_dout_o), 32'd0);
        check("rst_mid_busy",      32'(bus.busy_o),     32'd0);
        check("rst_mid_if_data",   bus.if_data_o,       32'd0);
        check("rst_mid_mem_rdata", bus.mem_rdata_o,     32'd0);
        check("rst_mid_mem_done",  32'(bus.mem_done_o), 32'd0);
        bus.mem_req_i = 1'b0;
        bus.mem_we_i  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        // Only byte 0 reached the RAM before reset; the rest must stay untouched.
        run_txn('{1'b0, 1'b0, 2'b10, 32'h0000_0500, 32'h0, 1'b1, 32'h0000_00EF, 6}, "post_rst");

        // Byte store into the UART window with the buffer reported full.
        @(negedge clk);
        bus.io_buffer_full_i = 1'b1;
        bus.mem_req_i        = 1'b1;
        bus.mem_we_i         = 1'b1;
        bus.mem_len_i        = 2'b00;
        bus.mem_addr_i       = 32'h0003_0000;
        bus.mem_wdata_i      = 32'h0000_0041;
`ifdef MEMCTRL_IO_FULL_WAIT_EN
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("io_stall_wr_%0d", k), 32'(bus.ram_wr_o), 32'd0);
        end
        bus.io_buffer_full_i = 1'b0;
`endif
        @(negedge clk);
        check("io_wr",   32'(bus.ram_wr_o),   32'd1);
        check("io_addr", bus.ram_a_o,         32'h0003_0000);
        check("io_dout", 32'(bus.ram_dout_o), 32'h0000_0041);
        @(negedge clk);
        check("io_done", 32'(bus.mem_done_o), 32'd1);
        bus.mem_req_i        = 1'b0;
        bus.mem_we_i         = 1'b0;
        bus.io_buffer_full_i = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
